// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU operand stage.
package alu_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned OP_SEL_W  = 3;

    typedef enum logic [OP_SEL_W-1:0] {
        REG_REG = 3'd0,
        REG_IMM = 3'd1,
        BRANCH  = 3'd2,
        JUMP    = 3'd3,
        LW_SW   = 3'd4,
        NONE    = 3'd5
    } op_sel_t;

endpackage

// File: rtl/operand_mux.sv
// Combinational ALU operand selection, extension and (with FORWARDING_EN) write-back forwarding.
module operand_mux
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned OFF_W    = 20,
    parameter int unsigned PC_W     = 20,
    parameter int unsigned OFF_SEXT = 0
) (
    input  logic [OP_SEL_W-1:0]  i_op_sel,
    input  logic                 i_imm_signed,
`ifdef FORWARDING_EN
    input  logic [REG_IDX_W-1:0] i_rs1_idx,
    input  logic [REG_IDX_W-1:0] i_rs2_idx,
    input  logic                 i_fwd_valid,
    input  logic [REG_IDX_W-1:0] i_fwd_idx,
    input  logic [DATA_W-1:0]    i_fwd_data,
`endif
    input  logic [DATA_W-1:0]    i_reg_out1,
    input  logic [DATA_W-1:0]    i_reg_out2,
    input  logic [IMM_W-1:0]     i_instr_imm,
    input  logic [OFF_W-1:0]     i_instr_offset,
    input  logic [PC_W-1:0]      i_pc,
    output logic [DATA_W-1:0]    o_op1_c,
    output logic [DATA_W-1:0]    o_op2_c
);

    localparam int unsigned IMM_PAD = DATA_W - IMM_W;
    localparam int unsigned OFF_PAD = DATA_W - OFF_W;
    localparam int unsigned PC_PAD  = DATA_W - PC_W;

    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_off_ext;
    logic [DATA_W-1:0] w_pc_ext;
    op_sel_t           w_op;

`ifdef FORWARDING_EN
    // Register $0 is hard-wired, so it is never replaced by a write-back value.
    assign w_src1 = (i_fwd_valid && (i_fwd_idx == i_rs1_idx) && (i_rs1_idx != '0)) ? i_fwd_data : i_reg_out1;
    assign w_src2 = (i_fwd_valid && (i_fwd_idx == i_rs2_idx) && (i_rs2_idx != '0)) ? i_fwd_data : i_reg_out2;
`else
    assign w_src1 = i_reg_out1;
    assign w_src2 = i_reg_out2;
`endif

    assign w_imm_ext = i_imm_signed ? {{IMM_PAD{i_instr_imm[IMM_W-1]}}, i_instr_imm}
                                    : {{IMM_PAD{1'b0}}, i_instr_imm};
    assign w_off_ext = (OFF_SEXT != 0) ? {{OFF_PAD{i_instr_offset[OFF_W-1]}}, i_instr_offset}
                                       : {{OFF_PAD{1'b0}}, i_instr_offset};
    assign w_pc_ext  = {{PC_PAD{1'b0}}, i_pc};
    assign w_op      = op_sel_t'(i_op_sel);

    always_comb begin
        o_op1_c = '0;
        o_op2_c = '0;
        case (w_op)
            REG_REG: begin o_op1_c = w_src1;   o_op2_c = w_src2;    end
            REG_IMM: begin o_op1_c = w_src1;   o_op2_c = w_imm_ext; end
            BRANCH:  begin o_op1_c = w_pc_ext; o_op2_c = w_off_ext; end
            JUMP:    begin o_op1_c = '0;       o_op2_c = w_off_ext; end
            LW_SW:   begin o_op1_c = w_src1;   o_op2_c = w_off_ext; end
            default: begin o_op1_c = '0;       o_op2_c = '0;        end
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: operand_mux feeding a 2-entry skid buffer with valid/ready handshake.
// Define FORWARDING_EN to add write-back forwarding (fwd_* ports).
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned OFF_W    = 20,
    parameter int unsigned PC_W     = 20,
    parameter int unsigned OFF_SEXT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_SEL_W-1:0]  op_sel,
    input  logic                 imm_signed,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic [DATA_W-1:0]    reg_out1,
    input  logic [DATA_W-1:0]    reg_out2,
    input  logic [IMM_W-1:0]     instr_imm,
    input  logic [OFF_W-1:0]     instr_offset,
    input  logic [PC_W-1:0]      pc,
`ifdef FORWARDING_EN
    input  logic                 fwd_valid,
    input  logic [REG_IDX_W-1:0] fwd_idx,
    input  logic [DATA_W-1:0]    fwd_data,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 2;

    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_push;
    logic              w_pop;

    logic [DATA_W-1:0] r_mem1 [DEPTH];
    logic [DATA_W-1:0] r_mem2 [DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_wr_ptr_nxt;
    logic              w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;

    operand_mux #(
        .DATA_W   (DATA_W),
        .IMM_W    (IMM_W),
        .OFF_W    (OFF_W),
        .PC_W     (PC_W),
        .OFF_SEXT (OFF_SEXT)
    ) u_operand_mux (
        .i_op_sel       (op_sel),
        .i_imm_signed   (imm_signed),
`ifdef FORWARDING_EN
        .i_rs1_idx      (rs1_idx),
        .i_rs2_idx      (rs2_idx),
        .i_fwd_valid    (fwd_valid),
        .i_fwd_idx      (fwd_idx),
        .i_fwd_data     (fwd_data),
`endif
        .i_reg_out1     (reg_out1),
        .i_reg_out2     (reg_out2),
        .i_instr_imm    (instr_imm),
        .i_instr_offset (instr_offset),
        .i_pc           (pc),
        .o_op1_c        (w_op1),
        .o_op2_c        (w_op2)
    );

`ifndef FORWARDING_EN
    // Source indices only matter for forwarding.
    logic w_unused_idx;
    assign w_unused_idx = ^{rs1_idx, rs2_idx};
`endif

    // Handshake flags derive only from the registered count.
    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign alu_in1 = out_valid ? r_mem1[r_rd_ptr] : '0;
    assign alu_in2 = out_valid ? r_mem2[r_rd_ptr] : '0;

    // Pointer/count next state; flush overrides any push or pop.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (flush) begin
            w_wr_ptr_nxt = 1'b0;
            w_rd_ptr_nxt = 1'b0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem1[i] <= '0;
                r_mem2[i] <= '0;
            end
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_push && !flush) begin
                r_mem1[r_wr_ptr] <= w_op1;
                r_mem2[r_wr_ptr] <= w_op2;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage (built with OFF_SEXT = 1; FORWARDING_EN optional).
module tb_alu_operand_stage;

    localparam int unsigned OFF_SEXT_TB = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_sel = 3'd0;
    logic        imm_signed = 1'b0;
    logic [3:0]  rs1_idx = 4'd0;
    logic [3:0]  rs2_idx = 4'd0;
    logic [31:0] reg_out1 = 32'd0;
    logic [31:0] reg_out2 = 32'd0;
    logic [15:0] instr_imm = 16'd0;
    logic [19:0] instr_offset = 20'd0;
    logic [19:0] pc = 20'd0;
`ifdef FORWARDING_EN
    logic        fwd_valid = 1'b0;
    logic [3:0]  fwd_idx = 4'd0;
    logic [31:0] fwd_data = 32'd0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;

    always #5 clk = ~clk;

    alu_operand_stage #(
        .DATA_W(32), .IMM_W(16), .OFF_W(20), .PC_W(20), .OFF_SEXT(OFF_SEXT_TB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_sel       (op_sel),
        .imm_signed   (imm_signed),
        .rs1_idx      (rs1_idx),
        .rs2_idx      (rs2_idx),
        .reg_out1     (reg_out1),
        .reg_out2     (reg_out2),
        .instr_imm    (instr_imm),
        .instr_offset (instr_offset),
        .pc           (pc),
`ifdef FORWARDING_EN
        .fwd_valid    (fwd_valid),
        .fwd_idx      (fwd_idx),
        .fwd_data     (fwd_data),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2)
    );

    logic [63:0] sb_q [$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference operand pair for the inputs currently driven.
    function automatic logic [63:0] model();
        logic [31:0] s1, s2, imm, off, pcx;
        s1 = reg_out1;
        s2 = reg_out2;
`ifdef FORWARDING_EN
        if (fwd_valid && fwd_idx == rs1_idx && rs1_idx != 4'd0) s1 = fwd_data;
        if (fwd_valid && fwd_idx == rs2_idx && rs2_idx != 4'd0) s2 = fwd_data;
`endif
        imm = imm_signed ? {{16{instr_imm[15]}}, instr_imm} : {16'h0, instr_imm};
        off = (OFF_SEXT_TB != 0) ? {{12{instr_offset[19]}}, instr_offset} : {12'h0, instr_offset};
        pcx = {12'h0, pc};
        case (op_sel)
            3'd0:    return {s1, s2};
            3'd1:    return {s1, imm};
            3'd2:    return {pcx, off};
            3'd3:    return {32'h0, off};
            3'd4:    return {s1, off};
            default: return 64'h0;
        endcase
    endfunction

    // One clock: observe handshake at negedge, update scoreboard, return #1 after posedge.
    task automatic cycle();
        logic [63:0] exp;
        int          occ;
        @(negedge clk);
        occ = sb_q.size();
        check("out_valid", 64'(out_valid), 64'(occ != 0));
        check("in_ready", 64'(in_ready), 64'(occ != 2));
        if (occ == 0) check("idle_zero", {alu_in1, alu_in2}, 64'h0);
        if (out_valid && out_ready && !flush) begin
            if (occ == 0) check("unexpected_out", {alu_in1, alu_in2}, 64'h0);
            else begin
                exp = sb_q.pop_front();
                check("data", {alu_in1, alu_in2}, exp);
            end
        end
        if (flush) sb_q.delete();
        else if (in_valid && occ < 2) sb_q.push_back(model());
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) cycle();
        check("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [15:0] imm, input logic isg, input logic [19:0] off,
                       input logic [19:0] p);
        op_sel = op; reg_out1 = r1; reg_out2 = r2; instr_imm = imm;
        imm_signed = isg; instr_offset = off; pc = p; in_valid = 1'b1;
    endtask

    initial begin
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu", {alu_in1, alu_in2}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed operand cases with fixed expected values.
        out_ready = 1'b0;
        req(3'd1, 32'h10, 32'h0, 16'hFFFF, 1'b1, 20'h0, 20'h0);
        cycle(); in_valid = 1'b0;
        check("reg_imm_sext", {alu_in1, alu_in2}, 64'h00000010_FFFFFFFF);
        drain(); out_ready = 1'b0;
        req(3'd1, 32'h10, 32'h0, 16'hFFFF, 1'b0, 20'h0, 20'h0);
        cycle(); in_valid = 1'b0;
        check("reg_imm_zext", {alu_in1, alu_in2}, 64'h00000010_0000FFFF);
        drain(); out_ready = 1'b0;
        req(3'd2, 32'h5, 32'h6, 16'h0, 1'b0, 20'hFFFFE, 20'h00400);
        cycle(); in_valid = 1'b0;
        check("branch", {alu_in1, alu_in2}, 64'h00000400_FFFFFFFE);
        drain(); out_ready = 1'b0;
        req(3'd3, 32'h5, 32'h6, 16'h0, 1'b0, 20'hFFFFE, 20'h00400);
        cycle(); in_valid = 1'b0;
        check("jump", {alu_in1, alu_in2}, 64'h00000000_FFFFFFFE);
        drain(); out_ready = 1'b0;
        req(3'd6, 32'h5, 32'h6, 16'h1, 1'b0, 20'h7, 20'h8);
        cycle(); in_valid = 1'b0;
        check("none", {alu_in1, alu_in2}, 64'h0);
        drain();

        // Backpressure: A, B accepted, C held until space frees up.
        out_ready = 1'b0;
        req(3'd0, 32'hA1, 32'hA2, 16'h0, 1'b0, 20'h0, 20'h0); cycle();
        req(3'd0, 32'hB1, 32'hB2, 16'h0, 1'b0, 20'h0, 20'h0); cycle();
        check("bp_full", 64'(in_ready), 64'd0);
        req(3'd0, 32'hC1, 32'hC2, 16'h0, 1'b0, 20'h0, 20'h0); cycle(); cycle();
        check("bp_head_a", {alu_in1, alu_in2}, 64'h000000A1_000000A2);
        out_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4 && sb_q.size() < 2; i++) cycle();
        in_valid = 1'b0;
        drain();

        // Flush at full occupancy with a same-cycle push.
        out_ready = 1'b0;
        req(3'd0, 32'h11, 32'h12, 16'h0, 1'b0, 20'h0, 20'h0); cycle();
        req(3'd0, 32'h21, 32'h22, 16'h0, 1'b0, 20'h0, 20'h0); cycle();
        req(3'd0, 32'hDD, 32'hDD, 16'h0, 1'b0, 20'h0, 20'h0);
        flush = 1'b1; cycle(); flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();

`ifdef FORWARDING_EN
        out_ready = 1'b0;
        req(3'd0, 32'h1, 32'h2, 16'h0, 1'b0, 20'h0, 20'h0);
        rs1_idx = 4'd3; fwd_valid = 1'b1; fwd_idx = 4'd3; fwd_data = 32'hABCD;
        cycle(); in_valid = 1'b0; fwd_valid = 1'b0;
        check("fwd_hit", 64'(alu_in1), 64'h0000ABCD);
        drain(); out_ready = 1'b0;
        req(3'd0, 32'h1, 32'h2, 16'h0, 1'b0, 20'h0, 20'h0);
        rs1_idx = 4'd0; fwd_valid = 1'b1; fwd_idx = 4'd0; fwd_data = 32'hABCD;
        cycle(); in_valid = 1'b0; fwd_valid = 1'b0;
        check("fwd_r0", 64'(alu_in1), 64'h00000001);
        drain();
`endif

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            req(3'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom), 1'($urandom),
                20'($urandom), 20'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rs1_idx   = 4'($urandom_range(0, 3));
            rs2_idx   = 4'($urandom_range(0, 3));
`ifdef FORWARDING_EN
            fwd_valid = 1'($urandom);
            fwd_idx   = 4'($urandom_range(0, 3));
            fwd_data  = $urandom;
`endif
            cycle();
        end
        flush = 1'b0;
        drain();

        // Asynchronous reset with one entry buffered.
        out_ready = 1'b0;
        req(3'd0, 32'h77, 32'h88, 16'h0, 1'b0, 20'h0, 20'h0); cycle(); in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_alu", {alu_in1, alu_in2}, 64'h0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
